// File: rtl/product_accumulator_pkg.sv
// Shared parameters and width helper for the product accumulator slice.
// The accumulator width is derived so a full group of maximum products never overflows.
package prod_accum_pkg;

  localparam int N_DEF   = 4;
  localparam int LEN_DEF = 4;

  function automatic int acc_width(input int n, input int len);
    return 2 * n + $clog2(len);
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / group-sum-out handshake bundle between the multiplier, accumulator and consumer.
// The slave side is the accumulator; the master side is the surrounding integrator or bench.
interface product_accumulator_if
  import prod_accum_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int LEN = LEN_DEF
);

  localparam int ACC_W = acc_width(N, LEN);

  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;

  modport slave (
    input  clr,
    input  in_valid,
    output in_ready,
    input  prod,
    output out_valid,
    input  out_ready,
    output sum
  );

  modport master (
    output clr,
    output in_valid,
    input  in_ready,
    output prod,
    input  out_valid,
    output out_ready,
    input  sum
  );

endinterface

// File: rtl/product_accumulator_term_counter.sv
// Counts accepted terms within a group and flags the final one.
// Wraps to zero after the last term; clr restarts the group.
module term_counter #(
  parameter int LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc,
  input  logic                   clr,
  output logic [$clog2(LEN)-1:0] cnt,
  output logic                   last
);

  localparam int CNT_W = $clog2(LEN);

  assign last = (cnt == CNT_W'(LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of LEN consecutive multiplier products and presents each group sum
// on a valid/ready output register, accumulating the next group while a result is held.
module product_accumulator
  import prod_accum_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int LEN = LEN_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);

  localparam int ACC_W = acc_width(N, LEN);
  localparam int CNT_W = $clog2(LEN);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] next_sum;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             in_ready;
  logic             accept;

  assign prod_ext = ACC_W'(bus.prod);
  assign next_sum = acc + prod_ext;

  // Only the final term can stall, and only while the previous sum is still unclaimed.
  assign in_ready = !bus.clr && !(last && out_valid_q && !bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;

  term_counter #(
    .LEN (LEN)
  ) u_term_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (bus.clr),
    .cnt   (cnt),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (bus.clr) begin
      acc <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
      end else if (cnt == '0) begin
        acc <= prod_ext;
      end else begin
        acc <= next_sum;
      end
    end
  end

  // A completing group reloads the register even during a handshake, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept && last) begin
      sum_q       <= next_sum;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scenario bench for product_accumulator: expected group sums go into a scoreboard queue
// as stimulus is driven and are popped at each output handshake.
module tb_product_accumulator;
  import prod_accum_pkg::*;

  localparam int N     = 4;
  localparam int LEN   = 4;
  localparam int ACC_W = acc_width(N, LEN);

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   stall_cycles = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] mon_exp;

  product_accumulator_if #(.N(N), .LEN(LEN)) bus();

  product_accumulator #(.N(N), .LEN(LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees exactly what the next edge will use.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_unexpected: got sum=%0d, required no output", bus.sum);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.sum !== mon_exp) begin
          errors++;
          $display("[TB] FAIL scoreboard_sum: got %0d, required %0d", bus.sum, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2*N-1:0] p);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.prod     = p;
    #1;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    stall_cycles += waited;
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, waited);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.prod      = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    checks++;
    if (bus.sum !== '0) begin
      errors++;
      $display("[TB] FAIL reset_sum: got %0d, required 0", bus.sum);
    end
    #10;
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    $display("[TB] basic group");
    bus.out_ready = 1'b1;
    exp_q.push_back(ACC_W'(269));
    send(8'd30);
    send(8'd70);
    send(8'd49);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_early_valid: got %b, required 0", bus.out_valid);
    end
    send(8'd120);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== ACC_W'(269)) begin
      errors++;
      $display("[TB] FAIL basic_sum: got valid=%b sum=%0d, required valid=1 sum=269", bus.out_valid, bus.sum);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_one_cycle: got out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_max();
    $display("[TB] max values");
    exp_q.push_back(ACC_W'(900));
    for (int i = 0; i < LEN; i++) send(8'd225);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== ACC_W'(900)) begin
      errors++;
      $display("[TB] FAIL max_sum: got valid=%b sum=%0d, required valid=1 sum=900", bus.out_valid, bus.sum);
    end
    step();
  endtask

  task automatic test_back_pressure();
    $display("[TB] back-pressure");
    bus.out_ready = 1'b1;
    exp_q.push_back(ACC_W'(269));
    exp_q.push_back(ACC_W'(10));
    send(8'd30);
    send(8'd70);
    send(8'd49);
    send(8'd120);
    bus.out_ready = 1'b0;
    send(8'd1);
    send(8'd2);
    send(8'd3);
    bus.in_valid = 1'b1;
    bus.prod     = 8'd4;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_stall: got in_ready=%b, required 0", bus.in_ready);
    end
    step();
    step();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_stall_held: got in_ready=%b, required 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== ACC_W'(269)) begin
      errors++;
      $display("[TB] FAIL bp_hold: got valid=%b sum=%0d, required valid=1 sum=269", bus.out_valid, bus.sum);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got in_ready=%b, required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== ACC_W'(10)) begin
      errors++;
      $display("[TB] FAIL bp_no_bubble: got valid=%b sum=%0d, required valid=1 sum=10", bus.out_valid, bus.sum);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int stalls_before;
    $display("[TB] back-to-back groups");
    bus.out_ready = 1'b1;
    stalls_before = stall_cycles;
    exp_q.push_back(ACC_W'(4));
    exp_q.push_back(ACC_W'(4));
    for (int i = 0; i < 2 * LEN; i++) send(8'd1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== ACC_W'(4)) begin
      errors++;
      $display("[TB] FAIL b2b_sum: got valid=%b sum=%0d, required valid=1 sum=4", bus.out_valid, bus.sum);
    end
    checks++;
    if (stall_cycles != stalls_before) begin
      errors++;
      $display("[TB] FAIL b2b_stalls: got %0d stall cycles, required 0", stall_cycles - stalls_before);
    end
    step();
  endtask

  task automatic test_clr();
    $display("[TB] clear mid-group");
    bus.out_ready = 1'b0;
    exp_q.push_back(ACC_W'(8));
    for (int i = 0; i < LEN; i++) send(8'd2);
    send(8'd5);
    send(8'd5);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b1;
    bus.prod     = 8'd9;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_in_ready: got %b, required 0", bus.in_ready);
    end
    step();
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (dut.cnt !== '0 || dut.acc !== '0) begin
      errors++;
      $display("[TB] FAIL clr_state: got cnt=%0d acc=%0d, required 0 and 0", dut.cnt, dut.acc);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== ACC_W'(8)) begin
      errors++;
      $display("[TB] FAIL clr_held: got valid=%b sum=%0d, required valid=1 sum=8", bus.out_valid, bus.sum);
    end
    bus.out_ready = 1'b1;
    exp_q.push_back(ACC_W'(4));
    for (int i = 0; i < LEN; i++) send(8'd1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== ACC_W'(4)) begin
      errors++;
      $display("[TB] FAIL clr_next_group: got valid=%b sum=%0d, required valid=1 sum=4", bus.out_valid, bus.sum);
    end
    step();
  endtask

  task automatic test_async_reset();
    $display("[TB] async reset mid-group");
    bus.out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) send(8'd3);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== ACC_W'(12)) begin
      errors++;
      $display("[TB] FAIL ar_held: got valid=%b sum=%0d, required valid=1 sum=12", bus.out_valid, bus.sum);
    end
    send(8'd2);
    send(8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== '0) begin
      errors++;
      $display("[TB] FAIL ar_outputs: got valid=%b sum=%0d, required valid=0 sum=0", bus.out_valid, bus.sum);
    end
    checks++;
    if (dut.acc !== '0 || dut.cnt !== '0) begin
      errors++;
      $display("[TB] FAIL ar_state: got acc=%0d cnt=%0d, required 0 and 0", dut.acc, dut.cnt);
    end
    bus.out_ready = 1'b1;
    step();
    #2;
    rst_n = 1'b1;
    step();
    exp_q.push_back(ACC_W'(8));
    for (int i = 0; i < LEN; i++) send(8'd2);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== ACC_W'(8)) begin
      errors++;
      $display("[TB] FAIL ar_next_group: got valid=%b sum=%0d, required valid=1 sum=8", bus.out_valid, bus.sum);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ar_drain: got out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_back_pressure();
    test_back_to_back();
    test_clr();
    test_async_reset();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d pending sums, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
